// File: rtl/program_mem_controller.sv
// program_mem_controller: round-robin arbiter relaying fetcher instruction reads onto program-memory read channels.
//   clk, reset                : clock (rising edge), asynchronous active-high reset
//   consumer_read_valid/_address : per-fetcher request, packed ADDR_BITS per consumer
//   consumer_read_ready/_data    : per-fetcher response, packed DATA_BITS per consumer
//   mem_read_valid/_address      : per-channel memory request, packed ADDR_BITS per channel
//   mem_read_ready/_data         : per-channel memory response, packed DATA_BITS per channel
module program_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    output logic [NUM_CHANNELS-1:0]            mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    input  logic [NUM_CHANNELS-1:0]            mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]  mem_read_data
);
    localparam int CW = NUM_CONSUMERS > 1 ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [1:0] IDLE = 2'd0, WAITING = 2'd1, RELAYING = 2'd2;
    logic [1:0]               state_q [NUM_CHANNELS];
    logic [CW-1:0]            idx_q   [NUM_CHANNELS];
    logic [CW-1:0]            gnt_idx [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  gnt;
    logic [NUM_CONSUMERS-1:0] claim_q, avail;
    logic [CW-1:0]            rr_q, rr_d;
    always_comb begin
        avail = consumer_read_valid & ~claim_q & ~consumer_read_ready;
        rr_d  = rr_q;
        gnt   = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            gnt_idx[c] = '0;
            // reverse scan so the smallest offset from rr_q is the one left standing
            if (state_q[c] == IDLE)
                for (int k = NUM_CONSUMERS - 1; k >= 0; k--)
                    if (avail[CW'((int'(rr_q) + k) % NUM_CONSUMERS)]) begin
                        gnt[c]     = 1'b1;
                        gnt_idx[c] = CW'((int'(rr_q) + k) % NUM_CONSUMERS);
                    end
            // removing the winner keeps higher channels from granting it again
            if (gnt[c]) begin
                avail[gnt_idx[c]] = 1'b0;
                rr_d = CW'((int'(gnt_idx[c]) + 1) % NUM_CONSUMERS);
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                state_q[c] <= IDLE;
                idx_q[c]   <= '0;
            end
            claim_q             <= '0;
            rr_q                <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
            mem_read_valid      <= '0;
            mem_read_address    <= '0;
        end else begin
            rr_q <= rr_d;
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                case (state_q[c])
                    IDLE: if (gnt[c]) begin
                        idx_q[c] <= gnt_idx[c];
                        mem_read_address[c*ADDR_BITS +: ADDR_BITS] <=
                            consumer_read_address[gnt_idx[c]*ADDR_BITS +: ADDR_BITS];
                        mem_read_valid[c]   <= 1'b1;
                        claim_q[gnt_idx[c]] <= 1'b1;
                        state_q[c]          <= WAITING;
                    end
                    WAITING: if (mem_read_ready[c]) begin
                        mem_read_valid[c] <= 1'b0;
                        consumer_read_data[idx_q[c]*DATA_BITS +: DATA_BITS] <=
                            mem_read_data[c*DATA_BITS +: DATA_BITS];
                        consumer_read_ready[idx_q[c]] <= 1'b1;
                        state_q[c]                    <= RELAYING;
                    end
                    RELAYING: if (!consumer_read_valid[idx_q[c]]) begin
                        consumer_read_ready[idx_q[c]] <= 1'b0;
                        claim_q[idx_q[c]]             <= 1'b0;
                        state_q[c]                    <= IDLE;
                    end
                    default: state_q[c] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_program_mem_controller.sv
// tb_program_mem_controller: scoreboard bench for one-channel and two-channel controllers.
module tb_program_mem_controller;
    logic        clk, reset;
    logic [3:0]  v1, r1, v2, r2;
    logic [31:0] a1, a2, md2;
    logic [63:0] rd1, rd2;
    logic [0:0]  mv1, mr1;
    logic [7:0]  ma1;
    logic [15:0] md1, ma2;
    logic [1:0]  mv2, mr2;
    int errors = 0, checks = 0;
    typedef struct {int id; logic [15:0] data;} exp_t;
    exp_t exp_q[$];
    exp_t e;

    program_mem_controller #(.NUM_CHANNELS(1)) d1 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v1), .consumer_read_address(a1),
        .consumer_read_ready(r1), .consumer_read_data(rd1),
        .mem_read_valid(mv1), .mem_read_address(ma1),
        .mem_read_ready(mr1), .mem_read_data(md1));

    program_mem_controller #(.NUM_CHANNELS(2)) d2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(v2), .consumer_read_address(a2),
        .consumer_read_ready(r2), .consumer_read_data(rd2),
        .mem_read_valid(mv2), .mem_read_address(ma2),
        .mem_read_ready(mr2), .mem_read_data(md2));

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1; v1 = 0; a1 = 0; mr1 = 0; md1 = 0; v2 = 0; a2 = 0; mr2 = 0; md2 = 0;
        tick(); tick();
        reset = 0;
    endtask

    function automatic logic [15:0] dat(input logic [7:0] a);
        return {~a, a};
    endfunction

    task automatic serve(input int id, input logic [7:0] addr, input logic [15:0] d, input int lat);
        int n = 0;
        while (!mv1[0] && n < 20) begin tick(); n++; end
        checks++;
        if (mv1[0] !== 1'b1 || ma1 !== addr)
            begin errors++; $display("FAIL serve_req c%0d: valid=%b addr=%h, want 1 %h", id, mv1[0], ma1, addr); end
        for (int k = 0; k < lat; k++) begin
            tick();
            checks++;
            if (mv1[0] !== 1'b1 || ma1 !== addr || r1 !== 4'b0)
                begin errors++; $display("FAIL serve_hold c%0d cyc%0d: valid=%b addr=%h ready=%b, want 1 %h 0000", id, k, mv1[0], ma1, r1, addr); end
        end
        mr1 = 1; md1 = d;
        exp_q.push_back('{id, d});
        tick();
        mr1 = 0; md1 = 0;
        e = exp_q.pop_front();
        checks++;
        if (r1 !== 4'(1 << e.id) || rd1[e.id*16 +: 16] !== e.data || mv1[0] !== 1'b0)
            begin errors++; $display("FAIL serve_resp c%0d: ready=%b data=%h mvalid=%b, want %b %h 0", e.id, r1, rd1[e.id*16 +: 16], mv1[0], 4'(1 << e.id), e.data); end
        tick();
        checks++;
        if (r1[id] !== 1'b1)
            begin errors++; $display("FAIL serve_window c%0d: ready=%b, want 1", id, r1[id]); end
        v1[id] = 0;
        tick();
        checks++;
        if (r1[id] !== 1'b0 || rd1[id*16 +: 16] !== d || mv1[0] !== 1'b0)
            begin errors++; $display("FAIL serve_release c%0d: ready=%b data=%h mvalid=%b, want 0 %h 0", id, r1[id], rd1[id*16 +: 16], mv1[0], d); end
    endtask

    task automatic test_reset;
        reset = 1; v1 = 4'hF; v2 = 4'hF; a1 = '1; a2 = '1; mr1 = 1; mr2 = 2'b11; md1 = '1; md2 = '1;
        tick(); tick();
        checks++;
        if ({r1, rd1, mv1, ma1, r2, rd2, mv2, ma2} !== '0)
            begin errors++; $display("FAIL reset_outputs: r1=%b rd1=%h mv1=%b ma1=%h r2=%b rd2=%h mv2=%b ma2=%h, want all 0", r1, rd1, mv1, ma1, r2, rd2, mv2, ma2); end
        do_reset();
    endtask

    task automatic test_single;
        do_reset();
        v1[0] = 1; a1[7:0] = 8'h05;
        checks++;
        if (mv1 !== 1'b0)
            begin errors++; $display("FAIL single_no_comb: mvalid=%b, want 0", mv1); end
        tick();
        checks++;
        if (mv1 !== 1'b1 || ma1 !== 8'h05)
            begin errors++; $display("FAIL single_latency: mvalid=%b addr=%h, want 1 05", mv1, ma1); end
        serve(0, 8'h05, 16'hA1B2, 0);
    endtask

    task automatic test_all_consumers;
        do_reset();
        a1 = {8'h13, 8'h12, 8'h11, 8'h10};
        v1 = 4'hF;
        for (int i = 0; i < 4; i++) serve(i, 8'(8'h10 + i), dat(8'(8'h10 + i)), 2);
    endtask

    task automatic test_round_robin;
        do_reset();
        v1[0] = 1; a1[7:0] = 8'h20;
        tick();
        v1[3] = 1; a1[31:24] = 8'h23;
        serve(0, 8'h20, dat(8'h20), 1);
        v1[0] = 1; a1[7:0] = 8'h30;
        serve(3, 8'h23, dat(8'h23), 1);
        serve(0, 8'h30, dat(8'h30), 1);
    endtask

    task automatic test_two_channels;
        do_reset();
        a2[15:8] = 8'h41; a2[23:16] = 8'h42;
        v2 = 4'b0110;
        tick();
        checks++;
        if (mv2 !== 2'b11 || ma2 !== {8'h42, 8'h41} || r2 !== 4'b0)
            begin errors++; $display("FAIL two_ch_grant: mvalid=%b addr=%h ready=%b, want 11 4241 0000", mv2, ma2, r2); end
        mr2 = 2'b10; md2[31:16] = dat(8'h42);
        exp_q.push_back('{2, dat(8'h42)});
        tick();
        mr2 = 0; md2 = 0;
        e = exp_q.pop_front();
        checks++;
        if (r2 !== 4'(1 << e.id) || rd2[e.id*16 +: 16] !== e.data || mv2 !== 2'b01)
            begin errors++; $display("FAIL two_ch_first: ready=%b data=%h mvalid=%b, want 0100 %h 01", r2, rd2[e.id*16 +: 16], mv2, e.data); end
        mr2 = 2'b01; md2[15:0] = dat(8'h41);
        exp_q.push_back('{1, dat(8'h41)});
        tick();
        mr2 = 0; md2 = 0;
        e = exp_q.pop_front();
        checks++;
        if (r2 !== 4'b0110 || rd2[e.id*16 +: 16] !== e.data || rd2[47:32] !== dat(8'h42) || mv2 !== 2'b00)
            begin errors++; $display("FAIL two_ch_second: ready=%b data1=%h data2=%h mvalid=%b, want 0110 %h %h 00", r2, rd2[e.id*16 +: 16], rd2[47:32], mv2, e.data, dat(8'h42)); end
        v2 = 0;
        tick(); tick();
        checks++;
        if (r2 !== 4'b0 || mv2 !== 2'b00)
            begin errors++; $display("FAIL two_ch_release: ready=%b mvalid=%b, want 0000 00", r2, mv2); end
    endtask

    task automatic test_async_reset;
        do_reset();
        v1[0] = 1; a1[7:0] = 8'h55;
        tick(); tick();
        checks++;
        if (mv1 !== 1'b1 || ma1 !== 8'h55)
            begin errors++; $display("FAIL areset_pre: mvalid=%b addr=%h, want 1 55", mv1, ma1); end
        #2 reset = 1;
        #1;
        checks++;
        if (mv1 !== 1'b0 || ma1 !== 8'h00 || r1 !== 4'b0 || rd1 !== 64'b0)
            begin errors++; $display("FAIL areset_async: mvalid=%b addr=%h ready=%b data=%h, want 0 00 0000 0", mv1, ma1, r1, rd1); end
        v1 = 0;
        tick();
        reset = 0;
        mr1 = 1; md1 = 16'hFFFF;
        tick(); tick();
        checks++;
        if (r1 !== 4'b0 || rd1 !== 64'b0 || mv1 !== 1'b0)
            begin errors++; $display("FAIL areset_late_ready: ready=%b data=%h mvalid=%b, want 0000 0 0", r1, rd1, mv1); end
        mr1 = 0; md1 = 0;
    endtask

    task automatic test_stall;
        do_reset();
        v1[1] = 1; a1[15:8] = 8'h66;
        serve(1, 8'h66, 16'h1234, 10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_consumers();
        test_round_robin();
        test_two_channels();
        test_async_reset();
        test_stall();
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL scoreboard_drain: %0d left, want 0", exp_q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
